// File: rtl/alu_pkg.sv
// alu_pkg: function-select codes, FSM states and helpers for the sequential ALU
package alu_pkg;
  localparam logic [4:0] ADD = 5'h02, ADDU = 5'h03, SUB = 5'h04, SUBU = 5'h05;
  localparam logic [4:0] LOG_AND = 5'h08, LOG_OR = 5'h09, LOG_XOR = 5'h0A, LOG_NOR = 5'h0B;
  localparam logic [4:0] SLL = 5'h0C, SRL = 5'h0D, SRA = 5'h0E, ROTL = 5'h1A, ROTR = 5'h1B;
  localparam logic [4:0] MULU = 5'h1C, DIVU = 5'h1D, MUL = 5'h1E, DIV = 5'h1F;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  function automatic logic is_multicycle(input logic [4:0] fs);
    return fs[4:2] == 3'b111;
  endfunction
endpackage

// File: rtl/alu_comb_n.sv
// alu_comb_n: combinational W-bit core for add/sub/logic and barrel shift/rotate
module alu_comb_n import alu_pkg::*; #(
  parameter int W = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic [W-1:0]   s,
  input  logic [W-1:0]   t,
  input  logic [4:0]     fs,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   y,
  output logic           c,
  output logic           v
);
  logic [W:0] add_x, sub_x, sl_x, sr_x, sa_x;
  always_comb begin
    add_x = {1'b0, s} + {1'b0, t};
    sub_x = {1'b0, s} - {1'b0, t};
    // one extra bit on each shift captures the last bit pushed out
    sl_x = {1'b0, t} << shamt;
    sr_x = {t, 1'b0} >> shamt;
    sa_x = $signed({t, 1'b0}) >>> shamt;
    y = s;
    c = 1'b0;
    v = 1'b0;
    case (fs)
      ADD, ADDU: begin
        y = add_x[W-1:0];
        c = add_x[W];
        v = (s[W-1] == t[W-1]) && (y[W-1] != s[W-1]);
      end
      SUB, SUBU: begin
        y = sub_x[W-1:0];
        c = sub_x[W];
        v = (s[W-1] != t[W-1]) && (y[W-1] != s[W-1]);
      end
      LOG_AND: y = s & t;
      LOG_OR:  y = s | t;
      LOG_XOR: y = s ^ t;
      LOG_NOR: y = ~(s | t);
      SLL:  begin y = sl_x[W-1:0]; c = sl_x[W]; end
      SRL:  begin y = sr_x[W:1]; c = sr_x[0]; end
      SRA:  begin y = sa_x[W:1]; c = sa_x[0]; end
      ROTL: begin y = (t << shamt) | (t >> (W - shamt)); c = sl_x[W]; end
      ROTR: begin y = (t >> shamt) | (t << (W - shamt)); c = sr_x[0]; end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: multi-cycle ALU with iterative shift-add multiply and restoring divide
module alu_seq_n import alu_pkg::*; #(
  parameter int W = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [4:0]     FS,
  input  logic [W-1:0]   S,
  input  logic [W-1:0]   T,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   Y_hi,
  output logic [W-1:0]   Y_lo,
  output logic           C,
  output logic           V,
  output logic           N,
  output logic           Z,
  output logic           DZ
);
  state_t state;
  logic [W-1:0] hi, lo, a, y, sm, tm, nx_hi, nx_lo, qf, rf;
  logic [2*W-1:0] pf;
  logic [W:0] sum, rsh, diff;
  logic [SHW-1:0] cnt;
  logic div_r, sgn_r, sn_r, tn_r, ovf_r, cy, vy, mc, dz_now, fix;
  logic nx_c, nx_v, nx_n, nx_z, nx_dz;
  alu_comb_n #(.W(W), .SHW(SHW)) u_core (
    .s(S), .t(T), .fs(FS), .shamt(shamt), .y(y), .c(cy), .v(vy)
  );
  assign mc = is_multicycle(FS);
  assign dz_now = mc && FS[0] && T == '0;
  assign sm = (FS[1] && S[W-1]) ? -S : S;
  assign tm = (FS[1] && T[W-1]) ? -T : T;
  assign fix = state == FIX;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    rsh = {hi, lo[W-1]};
    diff = rsh - {1'b0, a};
    pf = (sgn_r && (sn_r ^ tn_r)) ? -{hi, lo} : {hi, lo};
    qf = (sgn_r && (sn_r ^ tn_r)) ? -lo : lo;
    rf = (sgn_r && sn_r) ? -hi : hi;
    nx_hi = fix ? (div_r ? rf : pf[2*W-1:W]) : dz_now ? S : '0;
    nx_lo = fix ? (div_r ? qf : pf[W-1:0]) : dz_now ? '1 : y;
    nx_c = !fix && !dz_now && cy;
    nx_v = fix ? ovf_r : !dz_now && vy;
    nx_dz = !fix && dz_now;
    nx_n = fix ? sgn_r && (div_r ? nx_lo[W-1] : nx_hi[W-1]) :
           (FS == ADDU || FS == SUBU || FS == DIVU) ? 1'b0 : nx_lo[W-1];
    nx_z = fix ? (div_r ? ~|nx_lo : ~|{nx_hi, nx_lo}) : !nx_dz && ~|nx_lo;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      {busy, done, C, V, N, Z, DZ} <= '0;
      {Y_hi, Y_lo, hi, lo, a} <= '0;
      cnt <= '0;
      {div_r, sgn_r, sn_r, tn_r, ovf_r} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && mc && !dz_now) begin
            state <= ITER;
            busy <= 1'b1;
            cnt <= SHW'(W - 1);
            hi <= '0;
            a <= FS[0] ? tm : sm;
            lo <= FS[0] ? sm : tm;
            div_r <= FS[0];
            sgn_r <= FS[1];
            sn_r <= S[W-1];
            tn_r <= T[W-1];
            // most-negative / -1 overflows; the magnitude engine already yields MIN, 0
            ovf_r <= FS[1] && FS[0] && S == {1'b1, {(W-1){1'b0}}} && &T;
          end else if (start) begin
            state <= DONE;
            done <= 1'b1;
            {Y_hi, Y_lo, C, V, N, Z, DZ} <= {nx_hi, nx_lo, nx_c, nx_v, nx_n, nx_z, nx_dz};
          end else
            state <= IDLE;
        end
        ITER: begin
          hi <= div_r ? (diff[W] ? rsh[W-1:0] : diff[W-1:0]) : sum[W:1];
          lo <= div_r ? {lo[W-2:0], ~diff[W]} : {sum[0], lo[W-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          {Y_hi, Y_lo, C, V, N, Z, DZ} <= {nx_hi, nx_lo, nx_c, nx_v, nx_n, nx_z, nx_dz};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed and randomized checks of alu_seq_n against an arithmetic reference model
module tb_alu_seq_n;
  localparam logic [4:0] ADDU = 5'h03, SUBU = 5'h05, SLL = 5'h0C, SRL = 5'h0D, SRA = 5'h0E;
  localparam logic [4:0] ROTL = 5'h1A, ROTR = 5'h1B, MULU = 5'h1C, DIVU = 5'h1D, MUL = 5'h1E, DIV = 5'h1F;
  logic clk = 0, reset_n = 0, start = 0;
  logic [4:0] FS = 0, shamt = 0;
  logic [31:0] S = 0, T = 0, Y_hi, Y_lo;
  logic busy, done, C, V, N, Z, DZ;
  logic start16 = 0;
  logic [4:0] fs16 = 0;
  logic [3:0] sh16 = 0;
  logic [15:0] s16 = 0, t16 = 0, yh16, yl16;
  logic busy16, done16, c16, v16, n16, z16, dz16;
  int nvec = 0, nerr = 0;
  logic [4:0] codes [11] = '{ADDU, SUBU, SLL, SRL, SRA, ROTL, ROTR, MULU, DIVU, MUL, DIV};
  alu_seq_n #(.W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .FS(FS), .S(S), .T(T), .shamt(shamt),
    .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z), .DZ(DZ)
  );
  alu_seq_n #(.W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .FS(fs16), .S(s16), .T(t16), .shamt(sh16),
    .busy(busy16), .done(done16), .Y_hi(yh16), .Y_lo(yl16), .C(c16), .V(v16), .N(n16), .Z(z16), .DZ(dz16)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [4:0] f, input logic [31:0] s, input logic [31:0] t, input logic [4:0] sh,
                       output logic [63:0] y, output logic [4:0] fl, output int lat);
    longint ss, ts, r;
    logic [31:0] hi, lo, x;
    logic c, v, n, z, dz, multi;
    ss = longint'($signed(s));
    ts = longint'($signed(t));
    {hi, lo, c, v, dz} = '0;
    multi = f inside {MULU, DIVU, MUL, DIV};
    x = t;
    case (f)
      ADDU: begin
        {c, lo} = {1'b0, s} + {1'b0, t};
        r = ss + ts;
        v = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      SUBU: begin
        lo = s - t;
        c = s < t;
        r = ss - ts;
        v = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      SLL, SRL, SRA, ROTL, ROTR: begin
        for (int i = 0; i < int'(sh); i++) begin
          c = (f == SLL || f == ROTL) ? x[31] : x[0];
          case (f)
            SLL: x = x << 1;
            SRL: x = x >> 1;
            SRA: x = {x[31], x[31:1]};
            ROTL: x = {x[30:0], x[31]};
            default: x = {x[0], x[31:1]};
          endcase
        end
        lo = x;
      end
      MULU: {hi, lo} = {32'b0, s} * {32'b0, t};
      MUL: {hi, lo} = ss * ts;
      DIVU: if (t == 0) dz = 1; else begin lo = s / t; hi = s % t; end
      default: begin
        if (t == 0) dz = 1;
        else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin lo = s; hi = 0; v = 1; end
        else begin lo = 32'(ss / ts); hi = 32'(ss % ts); end
      end
    endcase
    if (dz) begin hi = s; lo = 32'hFFFF_FFFF; end
    n = (f == MUL) ? hi[31] : (f inside {ADDU, SUBU, MULU, DIVU}) ? 1'b0 : lo[31];
    z = dz ? 1'b0 : (f == MUL || f == MULU) ? ({hi, lo} == 0) : (lo == 0);
    y = {hi, lo};
    fl = {c, v, n, z, dz};
    lat = (multi && !dz) ? 34 : 1;
  endtask

  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] s, input logic [31:0] t,
                        input logic [4:0] sh);
    logic [63:0] ey;
    logic [4:0] efl;
    int elat, cyc;
    logic busy_ok;
    model(f, s, t, sh, ey, efl, elat);
    @(negedge clk);
    FS = f; S = s; T = t; shamt = sh; start = 1;
    @(posedge clk);
    #1 start = 0;
    FS = 5'($urandom); S = $urandom; T = $urandom; shamt = 5'($urandom);
    cyc = 0;
    busy_ok = 1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_ok = 0;
        break;
      end
      if (busy !== (elat > 1)) busy_ok = 0;
    end
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " busy"}, busy_ok, 1);
    chk({tag, " Y"}, {Y_hi, Y_lo}, ey);
    chk({tag, " flags"}, {C, V, N, Z, DZ}, efl);
    @(negedge clk);
    chk({tag, " hold"}, {done, Y_hi, Y_lo, C, V, N, Z, DZ}, {1'b0, ey, efl});
  endtask

  task automatic run16(input string tag, input logic [4:0] f, input logic [15:0] s, input logic [15:0] t,
                       input logic [31:0] ey, input logic [4:0] efl);
    int cyc;
    @(negedge clk);
    fs16 = f; s16 = s; t16 = t; start16 = 1;
    @(posedge clk);
    #1 start16 = 0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done16 === 1'b1) break;
    end
    chk({tag, " latency"}, cyc, 18);
    chk({tag, " Y"}, {yh16, yl16}, ey);
    chk({tag, " flags"}, {c16, v16, n16, z16, dz16}, efl);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    logic [4:0] f;
    repeat (3) @(negedge clk);
    chk("reset", {busy, done, Y_hi, Y_lo, C, V, N, Z, DZ}, 0);
    reset_n = 1;
    run_op("addu wrap", ADDU, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("mul -2*3", MUL, 32'hFFFF_FFFE, 32'h3, 0);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu dz", DIVU, 32'h5, 32'h0, 0);
    run_op("div dz", DIV, 32'hFFFF_FFF0, 32'h0, 0);
    run_op("rotr 1", ROTR, 32'h0, 32'h1, 1);
    run_op("sra 31", SRA, 32'h0, 32'h8000_0000, 31);
    run_op("sll 0", SLL, 32'h0, 32'hFFFF_FFFF, 0);
    run_op("subu ovf", SUBU, 32'h8000_0000, 32'h1, 0);
    run_op("mulu max", MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    // back-to-back: second start sampled in the DONE cycle
    @(negedge clk);
    FS = ADDU; S = 2; T = 3; start = 1;
    @(posedge clk);
    #1 FS = SUBU; S = 10; T = 4;
    @(negedge clk);
    chk("b2b first", {done, Y_lo}, {1'b1, 32'd5});
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("b2b second", {done, Y_lo}, {1'b1, 32'd6});
    for (int i = 0; i < 150; i++) begin
      f = codes[$urandom_range(0, 10)];
      run_op("random", f, pick(), pick(), 5'($urandom));
    end
    // abort: ignored restart at cycle 5, reset at cycle 10
    @(negedge clk);
    FS = MULU; S = 32'h1234; T = 32'h5678; start = 1;
    @(posedge clk);
    #1 start = 0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b1) seen = 1;
      start = (k == 5);
      if (k == 5) begin FS = ADDU; S = 1; T = 1; end
      if (k == 10) reset_n = 0;
    end
    chk("abort busy/no done", seen, 0);
    @(negedge clk);
    chk("abort reset", {busy, done, Y_hi, Y_lo, C, V, N, Z, DZ}, 0);
    reset_n = 1;
    run_op("post reset addu", ADDU, 32'h7FFF_FFFF, 32'h1, 0);
    run16("w16 mulu", MULU, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5'b00000);
    run16("w16 div ovf", DIV, 16'h8000, 16'hFFFF, 32'h0000_8000, 5'b01100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
